// File: rtl/pq_buffer_seq.sv
// Ping-pong buffer sequencer: clears both banks after reset, steers producer writes into the
// current bank, and on each step swaps banks and drains the previous one with zero-behind.
module pq_buffer_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_step,
  output logic                  o_busy,
  output logic                  o_step_done,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0] o_out_addr,
  output logic                  o_out_last,
  input  logic [DATA_WIDTH-1:0] i_dout2,
  output logic                  o_ctrl,
  output logic                  o_clear,
  output logic                  o_wr_en1,
  output logic [ADDR_WIDTH-1:0] o_wr_addr1,
  output logic [DATA_WIDTH-1:0] o_din1,
  output logic                  o_rd_en1,
  output logic                  o_rd_en2,
  output logic [ADDR_WIDTH-1:0] o_rd_addr2,
  output logic                  o_wr_en2,
  output logic [ADDR_WIDTH-1:0] o_wr_addr2,
  output logic [DATA_WIDTH-1:0] o_din2
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  localparam logic [1:0] S_CLR   = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;        // clear sweep address, then drain read pointer
  logic                  r_rd_issued;  // every address of the drain bank has been read
  logic                  r_ctrl;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_step_done;

  logic w_in_clr;
  logic w_in_idle;
  logic w_in_drain;
  logic w_port1_open;
  logic w_rd_en2;
  logic w_hs;
  logic w_last;

  assign w_in_clr     = (r_state == S_CLR);
  assign w_in_idle    = (r_state == S_IDLE);
  assign w_in_drain   = (r_state == S_DRAIN);
  assign w_port1_open = w_in_idle | w_in_drain;

  // Issue a read only when the output slot is free or being emptied this cycle.
  assign w_rd_en2 = w_in_drain & ~r_rd_issued & (~r_out_valid | i_out_ready);
  assign w_hs     = r_out_valid & i_out_ready;
  assign w_last   = r_out_valid & (r_out_addr == LAST_ADDR);

  // clear and busy are forced low while reset is held even though the state is CLR.
  assign o_busy      = i_rst_n & ~w_in_idle;
  assign o_clear     = i_rst_n & w_in_clr;
  assign o_step_done = r_step_done;
  assign o_ctrl      = r_ctrl;

  assign o_wr_ready  = w_port1_open;
  assign o_wr_en1    = w_port1_open & i_wr_req;
  assign o_wr_addr1  = w_in_clr ? r_cnt : i_wr_addr;
  assign o_din1      = w_port1_open ? i_wr_data : '0;
  assign o_rd_en1    = 1'b0;

  assign o_rd_en2    = w_rd_en2;
  assign o_rd_addr2  = r_cnt;
  assign o_wr_en2    = w_hs;
  assign o_wr_addr2  = r_out_addr;
  assign o_din2      = '0;

  assign o_out_valid = r_out_valid;
  assign o_out_data  = i_dout2;
  assign o_out_addr  = r_out_addr;
  assign o_out_last  = w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_CLR;
      r_cnt       <= '0;
      r_rd_issued <= 1'b0;
      r_ctrl      <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        S_CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_step) begin
            r_ctrl      <= ~r_ctrl;
            r_cnt       <= '0;
            r_rd_issued <= 1'b0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_rd_en2) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) r_rd_issued <= 1'b1;
          end
          if (w_hs && w_last) begin
            r_step_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_CLR;
      endcase
    end
  end

  // Output slot: loaded by a read, held until the consumer takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else if (w_in_drain) begin
      r_out_valid <= w_rd_en2 | (r_out_valid & ~i_out_ready);
      if (w_rd_en2) r_out_addr <= r_cnt;
    end
  end

endmodule

// File: tb/tb_pq_buffer_seq.sv
// Bench for pq_buffer_seq: behavioural two-bank buffer plus a per-bank content scoreboard.
module tb_pq_buffer_seq;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          step = 1'b0;
  logic          wr_req = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          busy, step_done, wr_ready, out_valid, out_last, ctrl, clear;
  logic          wr_en1, rd_en1, rd_en2, wr_en2;
  logic [DW-1:0] out_data, din1, din2;
  logic [DW-1:0] dout2 = '0;
  logic [AW-1:0] out_addr, wr_addr1, rd_addr2, wr_addr2;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem      [2][DEPTH];
  logic [DW-1:0] ref_bank [2][DEPTH];
  logic [DW-1:0] exp_d    [DEPTH];
  int            cur = 0;

  always #5 clk = ~clk;

  pq_buffer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .o_busy(busy), .o_step_done(step_done),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_addr(out_addr), .o_out_last(out_last), .i_dout2(dout2), .o_ctrl(ctrl),
    .o_clear(clear), .o_wr_en1(wr_en1), .o_wr_addr1(wr_addr1), .o_din1(din1),
    .o_rd_en1(rd_en1), .o_rd_en2(rd_en2), .o_rd_addr2(rd_addr2), .o_wr_en2(wr_en2),
    .o_wr_addr2(wr_addr2), .o_din2(din2)
  );

  // Ping-pong buffer: port 1 writes bank ctrl, port 2 reads/writes bank !ctrl, clear zeroes both.
  always @(posedge clk) begin
    if (clear) begin
      mem[0][wr_addr1] <= '0;
      mem[1][wr_addr1] <= '0;
    end
    if (wr_en1) mem[ctrl][wr_addr1] <= din1;
    if (rd_en2) dout2 <= mem[~ctrl][rd_addr2];
    if (wr_en2) mem[~ctrl][wr_addr2] <= din2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_reset();
    cur = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) ref_bank[b][i] = '0;
  endtask

  // Clear sweep right after reset release; steps and writes offered here must be ignored.
  task automatic clr_phase();
    for (int i = 0; i < DEPTH; i++) begin
      step    = (i % 2) == 1;
      wr_req  = 1'b1;
      wr_addr = AW'($urandom_range(0, DEPTH-1));
      wr_data = DW'($urandom);
      #1;
      chk("clr_clear", clear, 1);
      chk("clr_addr", wr_addr1, i);
      chk("clr_busy", busy, 1);
      chk("clr_wr_ready", wr_ready, 0);
      chk("clr_wr_en1", wr_en1, 0);
      chk("clr_ctrl", ctrl, 0);
      tick();
    end
    step = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("idle_clear", clear, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ctrl", ctrl, 0);
    chk("idle_wr_ready", wr_ready, 1);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_en1", wr_en1, 1);
    chk("wr_addr1", wr_addr1, a);
    chk("din1", din1, d);
    ref_bank[cur][a] = d;
    tick();
    wr_req = 1'b0;
  endtask

  // Step, optionally with a same-cycle write that must land in the pre-swap bank.
  task automatic do_step(input bit with_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step = 1'b1;
    if (with_wr) begin
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      ref_bank[cur][a] = d;
    end
    tick();
    step = 1'b0;
    wr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_d[i] = ref_bank[cur][i];
      ref_bank[cur][i] = '0;
    end
    cur ^= 1;
    chk("step_ctrl", ctrl, cur);
    chk("step_busy", busy, 1);
  endtask

  // mode 0: always ready, 1: ready toggles, 2: random ready. abort_at < 0 means no reset.
  task automatic drain(input int mode, input bit wr_rand, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit held = 0;
    bit rdy;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    while (idx < DEPTH && cyc < 200) begin
      if (idx == abort_at) begin
        out_ready = 1'b0; step = 1'b0; wr_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clear", clear, 0);
        chk("abort_ctrl", ctrl, 0);
        ref_reset();
        tick();
        rst_n = 1'b1;
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      step      = ($urandom_range(0, 3) == 0);
      wr_req    = wr_rand && ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, DEPTH-1));
      wr_data   = DW'($urandom);
      #1;
      chk("drain_ctrl", ctrl, cur);
      chk("drain_busy", busy, 1);
      chk("drain_step_done", step_done, 0);
      if (wr_req) begin
        chk("drain_wr_ready", wr_ready, 1);
        ref_bank[cur][wr_addr] = wr_data;
      end
      if (out_valid) begin
        if (held) begin
          chk("hold_addr", out_addr, h_addr);
          chk("hold_data", out_data, h_data);
        end
        if (rdy) begin
          chk("drain_addr", out_addr, idx);
          chk("drain_data", out_data, exp_d[idx]);
          chk("drain_last", out_last, idx == DEPTH-1);
          chk("zero_behind_en", wr_en2, 1);
          chk("zero_behind_addr", wr_addr2, idx);
          chk("zero_behind_din", din2, 0);
          idx++;
          held = 0;
        end else begin
          held = 1; h_addr = out_addr; h_data = out_data;
        end
      end else if (held) begin
        chk("valid_retract", out_valid, 1);
      end
      tick();
      cyc++;
    end
    step = 1'b0; wr_req = 1'b0; out_ready = 1'b0;
    chk("drain_count", idx, DEPTH);
    #1;
    chk("step_done_pulse", step_done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    tick();
    chk("step_done_clear", step_done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mem[b][i] = DW'($urandom);
    ref_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_clear", clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_rd_en1", rd_en1, 0);
    chk("rst_rd_en2", rd_en2, 0);
    chk("rst_wr_en2", wr_en2, 0);
    chk("rst_wr_en1", wr_en1, 0);
    chk("rst_din1", din1, 0);
    chk("rst_din2", din2, 0);
    rst_n = 1'b1;
    clr_phase();

    // Directed pattern, full-rate drain.
    write(4'd3, 8'hA5);
    write(4'd15, 8'h3C);
    do_step(1'b0, '0, '0);
    drain(0, 1'b0, -1);

    // Two steps with no writes: first drains the cleared bank, second the zero-behind bank.
    do_step(1'b0, '0, '0);
    drain(0, 1'b0, -1);
    do_step(1'b0, '0, '0);
    drain(0, 1'b0, -1);

    // Same pattern with a stalling consumer.
    write(4'd3, 8'hA5);
    write(4'd15, 8'h3C);
    do_step(1'b0, '0, '0);
    drain(1, 1'b0, -1);

    // Randomized rounds, including writes during drain and on the step cycle.
    repeat (5) begin
      int n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) write(AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      do_step(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      drain(2, 1'b1, -1);
    end

    // Reset mid-drain, full clear sweep again, then an all-zero drain.
    write(4'd1, 8'h77);
    write(4'd9, 8'h42);
    do_step(1'b0, '0, '0);
    drain(0, 1'b0, 7);
    clr_phase();
    do_step(1'b0, '0, '0);
    drain(0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
